// File: rtl/cordic_rot_seq.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_rot_seq
//  Description : Iterative CORDIC rotation-mode sequencer. Accepts a start
//                vector (x, y) and a target angle, then performs ITER
//                shift-add micro-rotations, one per clock. Each micro-rotation
//                reads arctan(2^-i) from an external combinational LUT.
//                Results are uncompensated (gain K ~ 1.6468).
//  Ports       :
//      clk        in   1        clock, rising-edge active
//      rst_n      in   1        synchronous active-low reset
//      start      in   1        request, accepted only while busy = 0
//      x_in       in   WIDTH    signed start vector x
//      y_in       in   WIDTH    signed start vector y
//      angle_in   in   8        signed target angle (100 = 45 degrees)
//      lut_count  out  3        LUT index (current iteration, 0 otherwise)
//      lut_angle  in   8        unsigned arctan(2^-lut_count)
//      busy       out  1        high from acceptance until back in idle
//      done       out  1        one-cycle pulse, results valid
//      x_out      out  WIDTH+2  signed rotated x
//      y_out      out  WIDTH+2  signed rotated y
//      z_out      out  10       signed residual angle
//  Revision    : 1.0  initial release
// ============================================================================
module cordic_rot_seq #(
    parameter int WIDTH = 16,
    parameter int ITER  = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [WIDTH-1:0]       x_in,
    input  logic [WIDTH-1:0]       y_in,
    input  logic [7:0]             angle_in,
    output logic [2:0]             lut_count,
    input  logic [7:0]             lut_angle,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH+1:0]       x_out,
    output logic [WIDTH+1:0]       y_out,
    output logic [9:0]             z_out
);

    localparam int       c_XW   = WIDTH + 2;
    localparam int       c_ZW   = 10;
    localparam logic [2:0] c_LAST = 3'(ITER - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nx;

    logic signed [c_XW-1:0]   r_x;
    logic signed [c_XW-1:0]   r_y;
    logic signed [c_ZW-1:0]   r_z;
    logic [2:0]               r_i;

    logic signed [c_XW-1:0]   r_x_out;
    logic signed [c_XW-1:0]   r_y_out;
    logic signed [c_ZW-1:0]   r_z_out;

    logic                     w_accept;
    logic                     w_last;
    logic                     w_d_pos;
    logic signed [c_XW-1:0]   w_x_sh;
    logic signed [c_XW-1:0]   w_y_sh;
    logic signed [c_ZW-1:0]   w_lut_z;
    logic signed [c_XW-1:0]   w_x_nx;
    logic signed [c_XW-1:0]   w_y_nx;
    logic signed [c_ZW-1:0]   w_z_nx;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and control outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        lut_count  = 3'd0;
        unique case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_accept   = 1'b1;
                    w_state_nx = ST_ITER;
                end
            end
            ST_ITER: begin
                lut_count = r_i;
                if (w_last) begin
                    w_state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    assign w_last = (r_i == c_LAST);

    // ------------------------------------------------------------------------
    // Micro-rotation datapath. Direction follows the sign of the residual
    // angle; shifts are arithmetic so negative values floor toward -inf.
    // ------------------------------------------------------------------------
    assign w_d_pos = ~r_z[c_ZW-1];
    assign w_x_sh  = r_x >>> r_i;
    assign w_y_sh  = r_y >>> r_i;
    assign w_lut_z = {2'b00, lut_angle};

    assign w_x_nx  = w_d_pos ? (r_x - w_y_sh) : (r_x + w_y_sh);
    assign w_y_nx  = w_d_pos ? (r_y + w_x_sh) : (r_y - w_x_sh);
    assign w_z_nx  = w_d_pos ? (r_z - w_lut_z) : (r_z + w_lut_z);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x <= '0;
            r_y <= '0;
            r_z <= '0;
            r_i <= 3'd0;
        end else if (w_accept) begin
            r_x <= {{2{x_in[WIDTH-1]}}, x_in};
            r_y <= {{2{y_in[WIDTH-1]}}, y_in};
            r_z <= {{2{angle_in[7]}}, angle_in};
            r_i <= 3'd0;
        end else if (r_state == ST_ITER) begin
            r_x <= w_x_nx;
            r_y <= w_y_nx;
            r_z <= w_z_nx;
            // Return the index to 0 after the last step so the LUT index
            // reads 0 whenever the sequencer is not iterating.
            r_i <= w_last ? 3'd0 : r_i + 3'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Result registers: loaded with the final micro-rotation so they are
    // valid in the cycle done is asserted, then held until the next result.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x_out <= '0;
            r_y_out <= '0;
            r_z_out <= '0;
        end else if ((r_state == ST_ITER) && w_last) begin
            r_x_out <= w_x_nx;
            r_y_out <= w_y_nx;
            r_z_out <= w_z_nx;
        end
    end

    assign x_out = r_x_out;
    assign y_out = r_y_out;
    assign z_out = r_z_out;

endmodule
`default_nettype wire

// File: tb/tb_cordic_rot_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cordic_rot_seq
//  Description : Self-checking bench for cordic_rot_seq. Supplies the arctan
//                LUT, keeps a transaction-level reference model and compares
//                every DUT output on every falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cordic_rot_seq;

    localparam int WIDTH = 16;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [WIDTH-1:0]   x_in;
    logic [WIDTH-1:0]   y_in;
    logic [7:0]         angle_in;
    logic [2:0]         lut_count;
    logic [7:0]         lut_angle;
    logic               busy;
    logic               done;
    logic [WIDTH+1:0]   x_out;
    logic [WIDTH+1:0]   y_out;
    logic [9:0]         z_out;

    int errors = 0;
    int checks = 0;

    cordic_rot_seq #(.WIDTH(WIDTH), .ITER(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .x_in      (x_in),
        .y_in      (y_in),
        .angle_in  (angle_in),
        .lut_count (lut_count),
        .lut_angle (lut_angle),
        .busy      (busy),
        .done      (done),
        .x_out     (x_out),
        .y_out     (y_out),
        .z_out     (z_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // arctan(2^-i) in units where 100 = 45 degrees
    function automatic int lut_rom(input int i);
        case (i)
            0: return 100;
            1: return 59;
            2: return 31;
            3: return 16;
            4: return 8;
            5: return 4;
            6: return 2;
            default: return 0;
        endcase
    endfunction

    assign lut_angle = 8'(lut_rom(int'(lut_count)));

    // floor(a / 2^s)
    function automatic int fdiv(input int a, input int s);
        int d;
        int q;
        d = 1 << s;
        q = a / d;
        if ((a < 0) && (q * d != a)) q = q - 1;
        return q;
    endfunction

    typedef struct packed {
        int x;
        int y;
        int z;
    } res_t;

    function automatic res_t ref_rot(input int x0, input int y0, input int a0);
        res_t r;
        int x, y, z, xn, yn;
        x = x0; y = y0; z = a0;
        for (int i = 0; i < 7; i++) begin
            if (z >= 0) begin
                xn = x - fdiv(y, i);
                yn = y + fdiv(x, i);
                z  = z - lut_rom(i);
            end else begin
                xn = x + fdiv(y, i);
                yn = y - fdiv(x, i);
                z  = z + lut_rom(i);
            end
            x = xn; y = yn;
        end
        r.x = x; r.y = y; r.z = z;
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Reference model: phase -1 idle, 0..6 iterating, 7 result cycle.
    // ------------------------------------------------------------------------
    int   m_ph  = -1;
    bit   m_valid = 1'b0;
    res_t m_pend;
    res_t m_out;

    always @(posedge clk) begin
        m_valid <= 1'b1;
        if (!rst_n) begin
            m_ph  <= -1;
            m_out <= '0;
        end else if (m_ph == -1) begin
            if (start) begin
                m_ph   <= 0;
                m_pend <= ref_rot(int'($signed(x_in)), int'($signed(y_in)),
                                  int'($signed(angle_in)));
            end
        end else if (m_ph < 7) begin
            m_ph <= m_ph + 1;
            if (m_ph == 6) m_out <= m_pend;
        end else begin
            m_ph <= -1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (m_valid) begin
            check("busy", int'(busy), (m_ph != -1) ? 1 : 0);
            check("done", int'(done), (m_ph == 7) ? 1 : 0);
            check("lut_count", int'(lut_count), (m_ph >= 0 && m_ph <= 6) ? m_ph : 0);
            check("x_out", int'($signed(x_out)), m_out.x);
            check("y_out", int'($signed(y_out)), m_out.y);
            check("z_out", int'($signed(z_out)), m_out.z);
        end
    end

    // Pulse start for one cycle and wait for done; returns edges from
    // acceptance to the done cycle (-1 on timeout).
    task automatic run_op(input int xv, input int yv, input int av, output int lat);
        int k;
        @(negedge clk);
        x_in = 16'(xv); y_in = 16'(yv); angle_in = 8'(av);
        start = 1'b1;
        lat = -1;
        for (k = 1; k <= 30; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = k - 1;
                break;
            end
        end
        if (lat < 0) check("done_timeout", 0, 1);
    endtask

    task automatic pin(input string tag, input int ex, input int ey, input int ez);
        check({tag, "_x"}, int'($signed(x_out)), ex);
        check({tag, "_y"}, int'($signed(y_out)), ey);
        check({tag, "_z"}, int'($signed(z_out)), ez);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int d1, d2;
        rst_n = 1'b0; start = 1'b1;
        x_in = '0; y_in = '0; angle_in = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_lut", int'(lut_count), 0);
        pin("rst", 0, 0, 0);
        rst_n = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);

        // Zero angle: pure gain
        run_op(1000, 0, 0, lat);
        check("latency", lat, 7);
        pin("a0", 1646, -2, 0);
        @(negedge clk);
        check("done_width", int'(done), 0);

        // +45 degrees
        run_op(1000, 0, 100, lat);
        check("latency_p", lat, 7);
        pin("ap", 1144, 1184, -2);
        repeat (2) @(negedge clk);

        // start held high: accepted only every 9 cycles
        x_in = 16'd1000; y_in = 16'd0; angle_in = 8'd0;
        start = 1'b1;
        d1 = -1; d2 = -1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (done) begin
                if (d1 < 0) d1 = k; else d2 = k;
                pin("held", 1646, -2, 0);
            end
        end
        start = 1'b0;
        check("held_first", d1, 8);
        check("held_gap", d2 - d1, 9);
        repeat (3) @(negedge clk);

        // Reset in the middle of an operation
        @(negedge clk);
        x_in = 16'd1000; y_in = 16'd0; angle_in = 8'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_busy", int'(busy), 0);
        pin("mid_rst", 0, 0, 0);
        d1 = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) d1 = d1 + 1;
        end
        check("mid_rst_nodone", d1, 0);
        run_op(1000, 0, 0, lat);
        check("latency_r", lat, 7);
        pin("after_rst", 1646, -2, 0);
        @(negedge clk);

        // -45 degrees
        run_op(1000, 0, -100, lat);
        pin("an", 1182, -1144, -2);
        check("an_zmag", (int'($signed(z_out)) <= 2 && int'($signed(z_out)) >= -2) ? 1 : 0, 1);
        @(negedge clk);

        // Wider-range vectors, checked against the model only
        run_op(-20000, 15000, 127, lat);
        @(negedge clk);
        run_op(32767, 32767, -128, lat);
        @(negedge clk);
        run_op(-32768, -1, 37, lat);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
